// File: rtl/traffic_pkg.sv
// Shared state codes and lamp constants for the traffic phase sequencer.
// Optional night blink mode is enabled with TRAFFIC_NIGHT_MODE_EN.
package traffic_pkg;

  localparam int GREEN_IDX  = 0;
  localparam int YELLOW_IDX = 1;
  localparam int RED_IDX    = 2;

  localparam logic [2:0] LIGHT_G = 3'b001;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b100;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_G_LOAD = 3'd1;
  localparam logic [2:0] ST_G_RUN  = 3'd2;
  localparam logic [2:0] ST_Y_LOAD = 3'd3;
  localparam logic [2:0] ST_Y_RUN  = 3'd4;
  localparam logic [2:0] ST_R_LOAD = 3'd5;
  localparam logic [2:0] ST_R_RUN  = 3'd6;
`ifdef TRAFFIC_NIGHT_MODE_EN
  localparam logic [2:0] ST_NIGHT  = 3'd7;
`endif

endpackage

// File: rtl/traffic_phase_ctrl_blink_timer.sv
// Free-running half-period timer for the night-mode yellow blink.
// Only instantiated when TRAFFIC_NIGHT_MODE_EN is defined.
module blink_timer #(
  parameter int pBLINK_HALF  = 4,
  parameter int pBLINK_WIDTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic toggle_o
);

  localparam logic [pBLINK_WIDTH-1:0] LAST = pBLINK_WIDTH'(pBLINK_HALF - 1);

  logic [pBLINK_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Toggle fires on the last count of each half-period.
  assign toggle_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// GREEN -> YELLOW -> RED sequencer driving the phase down-counter (init/en, consumes last).
// Defining TRAFFIC_NIGHT_MODE_EN adds night_i and a blinking-yellow NIGHT state.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
`ifdef TRAFFIC_NIGHT_MODE_EN
  parameter int pBLINK_HALF  = 4,
  parameter int pBLINK_WIDTH = 3,
`endif
  parameter int pINIT_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_i,
  input  logic                   last_i,
`ifdef TRAFFIC_NIGHT_MODE_EN
  input  logic                   night_i,
`endif
  output logic [pINIT_WIDTH-1:0] init_o,
  output logic                   cnt_en_o,
  output logic [pINIT_WIDTH-1:0] light_o,
  output logic                   phase_start_o
);

  localparam logic [pINIT_WIDTH-1:0] LG = pINIT_WIDTH'(LIGHT_G);
  localparam logic [pINIT_WIDTH-1:0] LY = pINIT_WIDTH'(LIGHT_Y);
  localparam logic [pINIT_WIDTH-1:0] LR = pINIT_WIDTH'(LIGHT_R);

  logic [2:0]             r_state;
  logic [pINIT_WIDTH-1:0] r_init;
  logic                   r_en;
  logic [pINIT_WIDTH-1:0] r_light;
  logic                   r_start;

  logic [2:0]             w_next;
  logic [pINIT_WIDTH-1:0] w_init;
  logic                   w_en;
  logic [pINIT_WIDTH-1:0] w_light;
  logic                   w_start;

`ifdef TRAFFIC_NIGHT_MODE_EN
  logic w_blink_clr;
  logic w_blink_en;
  logic w_toggle;

  assign w_blink_clr = (w_next == ST_NIGHT) && (r_state != ST_NIGHT);
  assign w_blink_en  = (w_next == ST_NIGHT) && (r_state == ST_NIGHT);

  blink_timer #(
    .pBLINK_HALF  (pBLINK_HALF),
    .pBLINK_WIDTH (pBLINK_WIDTH)
  ) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (w_blink_clr),
    .en_i     (w_blink_en),
    .toggle_o (w_toggle)
  );
`endif

  // run_i low wins over everything; last_i is only looked at in RUN states.
  always_comb begin
    w_next = ST_IDLE;
    if (!run_i) begin
      w_next = ST_IDLE;
    end
`ifdef TRAFFIC_NIGHT_MODE_EN
    else if (night_i) begin
      w_next = ST_NIGHT;
    end
`endif
    else begin
      case (r_state)
        ST_IDLE:   w_next = ST_G_LOAD;
        ST_G_LOAD: w_next = ST_G_RUN;
        ST_G_RUN:  w_next = last_i ? ST_Y_LOAD : ST_G_RUN;
        ST_Y_LOAD: w_next = ST_Y_RUN;
        ST_Y_RUN:  w_next = last_i ? ST_R_LOAD : ST_Y_RUN;
        ST_R_LOAD: w_next = ST_R_RUN;
        ST_R_RUN:  w_next = last_i ? ST_G_LOAD : ST_R_RUN;
`ifdef TRAFFIC_NIGHT_MODE_EN
        ST_NIGHT:  w_next = ST_R_LOAD;
`endif
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers line up with r_state.
  always_comb begin
    w_init  = '0;
    w_en    = 1'b0;
    w_light = LR;
    w_start = 1'b0;
    case (w_next)
      ST_G_LOAD: begin w_init = LG; w_en = 1'b1; w_light = LG; w_start = 1'b1; end
      ST_G_RUN:  begin w_en = 1'b1; w_light = LG; end
      ST_Y_LOAD: begin w_init = LY; w_en = 1'b1; w_light = LY; w_start = 1'b1; end
      ST_Y_RUN:  begin w_en = 1'b1; w_light = LY; end
      ST_R_LOAD: begin w_init = LR; w_en = 1'b1; w_light = LR; w_start = 1'b1; end
      ST_R_RUN:  begin w_en = 1'b1; w_light = LR; end
`ifdef TRAFFIC_NIGHT_MODE_EN
      ST_NIGHT: begin
        if (r_state != ST_NIGHT) begin
          w_light = LY;
        end else if (w_toggle) begin
          w_light = r_light ^ LY;
        end else begin
          w_light = r_light;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_init  <= '0;
      r_en    <= 1'b0;
      r_light <= LR;
      r_start <= 1'b0;
    end else begin
      r_state <= w_next;
      r_init  <= w_init;
      r_en    <= w_en;
      r_light <= w_light;
      r_start <= w_start;
    end
  end

  assign init_o        = r_init;
  assign cnt_en_o      = r_en;
  assign light_o       = r_light;
  assign phase_start_o = r_start;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with a behavioural down-counter (inits 14/2/17).
module tb_traffic_phase_ctrl;

  typedef struct {
    logic [2:0] light;
    int         len;
    logic [2:0] init;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run_i;
  logic       last_i;
  logic [2:0] init_o;
  logic       cnt_en_o;
  logic [2:0] light_o;
  logic       phase_start_o;
`ifdef TRAFFIC_NIGHT_MODE_EN
  logic       night_i;
`endif

  logic       stuck;
  logic [4:0] cnt_q;
  int         tests;
  int         fails;
  exp_t       sb_q[$];

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (run_i),
    .last_i        (last_i),
`ifdef TRAFFIC_NIGHT_MODE_EN
    .night_i       (night_i),
`endif
    .init_o        (init_o),
    .cnt_en_o      (cnt_en_o),
    .light_o       (light_o),
    .phase_start_o (phase_start_o)
  );

  always #5 clk = ~clk;

  // Down-counter model: load on init pulse, count to 0, cleared when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (!cnt_en_o)        cnt_q <= '0;
    else if (init_o == 3'b001) cnt_q <= 5'd14;
    else if (init_o == 3'b010) cnt_q <= 5'd2;
    else if (init_o == 3'b100) cnt_q <= 5'd17;
    else if (cnt_q != 0)       cnt_q <= cnt_q - 5'd1;
  end

  assign last_i = stuck ? 1'b1 : (cnt_q == 5'd0);

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (!$onehot0(light_o) || !$onehot0(init_o)) begin
        fails++;
        $display("FAIL onehot: light=%b init=%b, required at most one bit set", light_o, init_o);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic capture_phase(output logic [2:0] l, output int n, output logic [2:0] ini,
                               output logic ok);
    l = light_o; ini = init_o; n = 1; ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (light_o !== l) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic go_green();
    run_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({light_o, cnt_en_o, init_o, phase_start_o} !== 8'b100_0_000_0) begin
      fails++;
      $display("FAIL reset: light=%b en=%b init=%b start=%b, required 100 0 000 0",
               light_o, cnt_en_o, init_o, phase_start_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (light_o !== 3'b100 || cnt_en_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: light=%b en=%b, required 100 0", light_o, cnt_en_o);
    end
    run_i = 1'b1;
    @(negedge clk);
    tests++;
    if (init_o !== 3'b001 || phase_start_o !== 1'b1 || cnt_en_o !== 1'b1 || light_o !== 3'b001) begin
      fails++;
      $display("FAIL start_load: init=%b start=%b en=%b light=%b, required 001 1 1 001",
               init_o, phase_start_o, cnt_en_o, light_o);
    end
    @(negedge clk);
    tests++;
    if (init_o !== 3'b000 || phase_start_o !== 1'b0 || cnt_en_o !== 1'b1) begin
      fails++;
      $display("FAIL start_pulse_len: init=%b start=%b en=%b, required 000 0 1",
               init_o, phase_start_o, cnt_en_o);
    end
    run_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_cycle();
    logic [2:0] l, ini; int n; logic ok; exp_t e;
    sb_q.push_back('{3'b001, 16, 3'b001});
    sb_q.push_back('{3'b010, 4, 3'b010});
    sb_q.push_back('{3'b100, 19, 3'b100});
    go_green();
    repeat (3) begin
      capture_phase(l, n, ini, ok);
      e = sb_q.pop_front();
      tests++;
      if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
        fails++;
        $display("FAIL full_cycle: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
                 ok, l, n, ini, e.light, e.len, e.init);
      end
    end
    tests++;
    if (init_o !== 3'b001 || phase_start_o !== 1'b1 || light_o !== 3'b001) begin
      fails++;
      $display("FAIL wrap_green: init=%b start=%b light=%b, required 001 1 001",
               init_o, phase_start_o, light_o);
    end
    run_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort_restart();
    logic [2:0] l, ini; int n; logic ok; exp_t e;
    sb_q.push_back('{3'b001, 16, 3'b001});
    go_green();
    capture_phase(l, n, ini, ok);
    e = sb_q.pop_front();
    tests++;
    if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
      fails++;
      $display("FAIL abort_green: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
               ok, l, n, ini, e.light, e.len, e.init);
    end
    repeat (2) @(negedge clk);
    run_i = 1'b0;
    @(negedge clk);
    tests++;
    if (light_o !== 3'b100 || cnt_en_o !== 1'b0 || init_o !== 3'b000) begin
      fails++;
      $display("FAIL abort_idle: light=%b en=%b init=%b, required 100 0 000", light_o, cnt_en_o, init_o);
    end
    sb_q.push_back('{3'b001, 16, 3'b001});
    go_green();
    capture_phase(l, n, ini, ok);
    e = sb_q.pop_front();
    tests++;
    if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
      fails++;
      $display("FAIL restart_green: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
               ok, l, n, ini, e.light, e.len, e.init);
    end
    run_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [2:0] l, ini; int n; logic ok; exp_t e;
    sb_q.push_back('{3'b001, 16, 3'b001});
    sb_q.push_back('{3'b010, 4, 3'b010});
    go_green();
    repeat (2) begin
      capture_phase(l, n, ini, ok);
      e = sb_q.pop_front();
      tests++;
      if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
        fails++;
        $display("FAIL areset_pre: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
                 ok, l, n, ini, e.light, e.len, e.init);
      end
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({light_o, cnt_en_o, init_o, phase_start_o} !== 8'b100_0_000_0) begin
      fails++;
      $display("FAIL areset_async: light=%b en=%b init=%b start=%b, required 100 0 000 0",
               light_o, cnt_en_o, init_o, phase_start_o);
    end
    #1 rst_n = 1'b1;
    sb_q.push_back('{3'b001, 16, 3'b001});
    @(negedge clk);
    capture_phase(l, n, ini, ok);
    e = sb_q.pop_front();
    tests++;
    if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
      fails++;
      $display("FAIL areset_restart: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
               ok, l, n, ini, e.light, e.len, e.init);
    end
    run_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stuck_last();
    logic [2:0] l, ini; int n; logic ok; exp_t e;
    stuck = 1'b1;
    sb_q.push_back('{3'b001, 2, 3'b001});
    sb_q.push_back('{3'b010, 2, 3'b010});
    sb_q.push_back('{3'b100, 2, 3'b100});
    sb_q.push_back('{3'b001, 2, 3'b001});
    go_green();
    repeat (4) begin
      capture_phase(l, n, ini, ok);
      e = sb_q.pop_front();
      tests++;
      if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
        fails++;
        $display("FAIL stuck_last: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
                 ok, l, n, ini, e.light, e.len, e.init);
      end
    end
    stuck = 1'b0;
    run_i = 1'b0;
    @(negedge clk);
  endtask

`ifdef TRAFFIC_NIGHT_MODE_EN
  task automatic test_night();
    logic [2:0] l, ini; int n; logic ok; exp_t e;
    go_green();
    repeat (3) @(negedge clk);
    night_i = 1'b1;
    @(negedge clk);
    tests++;
    if (light_o !== 3'b010 || cnt_en_o !== 1'b0 || init_o !== 3'b000) begin
      fails++;
      $display("FAIL night_entry: light=%b en=%b init=%b, required 010 0 000", light_o, cnt_en_o, init_o);
    end
    repeat (2) begin
      sb_q.push_back('{3'b010, 4, 3'b000});
      sb_q.push_back('{3'b000, 4, 3'b000});
    end
    repeat (4) begin
      capture_phase(l, n, ini, ok);
      e = sb_q.pop_front();
      tests++;
      if (!ok || l !== e.light || n !== e.len || ini !== e.init || cnt_en_o !== 1'b0) begin
        fails++;
        $display("FAIL night_blink: ok=%b light=%b len=%0d init=%b en=%b, required light=%b len=%0d init=%b en=0",
                 ok, l, n, ini, cnt_en_o, e.light, e.len, e.init);
      end
    end
    night_i = 1'b0;
    sb_q.push_back('{3'b100, 19, 3'b100});
    @(negedge clk);
    capture_phase(l, n, ini, ok);
    e = sb_q.pop_front();
    tests++;
    if (!ok || l !== e.light || n !== e.len || ini !== e.init) begin
      fails++;
      $display("FAIL night_exit: ok=%b light=%b len=%0d init=%b, required light=%b len=%0d init=%b",
               ok, l, n, ini, e.light, e.len, e.init);
    end
    run_i = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    clk = 1'b0; rst_n = 1'b0; run_i = 1'b0; stuck = 1'b0;
    tests = 0; fails = 0;
`ifdef TRAFFIC_NIGHT_MODE_EN
    night_i = 1'b0;
`endif
    test_reset();
    test_full_cycle();
    test_abort_restart();
    test_async_reset();
    test_stuck_last();
`ifdef TRAFFIC_NIGHT_MODE_EN
    test_night();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
